stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Minutes:seconds stopwatch that consumes the slow square wave from the clock divider and counts elapsed seconds in BCD from 00:00 to 59:59. Runs entirely in the `clock_in` domain and treats the divider output as a data input, not a clock. Provides start/stop, lap-freeze and zero control from one-cycle button pulses. Drives the seven-segment display driver with four BCD digits.

## Interface
- `MIN_MAX`, default 59: highest minute value before wrap; 1..99 (tens digit limit derived as `MIN_MAX/10`, ones limit 9 except at `MIN_MAX`).
- `clock_in`  in  1  system clock, 50 MHz; all state on its rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `tick_in`  in  1  divided clock from the clock divider; each rising edge = 1 s.
- `start_stop`  in  1  one-cycle pulse, debounced; toggles run/pause.
- `lap`  in  1  one-cycle pulse, debounced; lap freeze / zero.
- `disp_bcd`  out  16  `{min_tens, min_ones, sec_tens, sec_ones}`, 4 bits each.
- `running`  out  1  high in RUN or LAP.
- `lap_active`  out  1  high in LAP.
- `wrap`  out  1  one-cycle pulse when count rolls `MIN_MAX:59` → 00:00.

## Operation
- Edge detect: `tick_d` registers `tick_in`; `tick_rise = tick_in & ~tick_d`. `tick_d` resets to 0.
- Count: four BCD digit registers; increment by one second on `tick_rise` only in RUN or LAP. sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min_ones; min_ones 9→0 carries to min_tens; at `MIN_MAX:59` all digits go to 0 and `wrap` pulses.
- States: IDLE, RUN, PAUSE, LAP.
  - IDLE: count held at 00:00. `start_stop` → RUN. `lap` ignored.
  - RUN: `start_stop` → PAUSE. `lap` → LAP, snapshot register loads current count.
  - LAP: counting continues, display shows snapshot. `lap` → RUN (display live). `start_stop` → PAUSE (display live).
  - PAUSE: count held. `start_stop` → RUN. `lap` → IDLE, count zeroed.
- `disp_bcd` = snapshot in LAP, else live count.
- `start_stop` and `lap` in the same cycle: `start_stop` wins, `lap` is dropped.
- Pause does not reset the divider phase. Resume accuracy is ±1 s by design.
- `clear` in any state, including mid-count or in LAP: state IDLE, count, snapshot and `tick_d` all 0.

## Timing
- Reset values: `disp_bcd` = 16'h0000, `running` = 0, `lap_active` = 0, `wrap` = 0.
- Tick latency: count changes on the first edge where `tick_in`=1 and `tick_d`=0. `disp_bcd` shows the new value immediately after that edge; no extra pipeline stage.
- Control latency: a pulse sampled at edge k changes state at edge k. `running` and `lap_active` are decoded from the state register and valid after edge k.
- Tick coinciding with a control pulse:
  - RUN→PAUSE or LAP→PAUSE: the tick is counted.
  - PAUSE→RUN or IDLE→RUN: the tick is not counted.
  - RUN→LAP: the snapshot takes the pre-increment value.
- `wrap` is high for exactly the one cycle following the rolling edge.
- `tick_in` held high or low indefinitely: no counting. Only 0→1 transitions count.

## Structure
- Shared package/header `stopwatch_pkg`:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3
  - BCD digit limits: 9 and 5
  - display field offsets
- Sub-module `bcd_digit_counter`:
  - parameter `LIMIT`; ports `clock_in`, `clear`, `inc`, `zero`, `q[3:0]`, `carry`
  - `carry` = `inc & (q==LIMIT)`
  - instantiated four times and chained; minute wrap logic sits in the top level.

## Test plan
- Reset: assert `clear` 2 cycles during RUN at 00:37 → `disp_bcd`=0000, `running`=0 on the first cycle after.
- Carry chain: `start_stop`, then 70 `tick_in` rises → `disp_bcd`=16'h0110 (01:10), `running`=1.
- Wrap: preload by ticking to 59:59, one more rise → `disp_bcd`=0000, `wrap` high exactly 1 cycle, still RUN.
- Lap: at 00:05 pulse `lap`, then 3 rises → `disp_bcd`=0005, `lap_active`=1. Pulse `lap` → `disp_bcd`=0008.
- Pause/zero: run to 00:12, `start_stop`, 4 rises → `disp_bcd` stays 0012. `lap` → IDLE, 0000. Rises in IDLE → stays 0000.
- Simultaneous events:
  - `start_stop`+`lap` in RUN → PAUSE, no snapshot.
  - `start_stop` with `tick_rise` at 00:20 → PAUSE showing 00:21.
  - `start_stop` with `tick_rise` in PAUSE at 00:21 → RUN, still 00:21.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: control states, BCD digit limits
// and the nibble positions of each digit inside the 16-bit display word.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_e;

   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;

   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_TENS_LSB = 4;
   localparam int MIN_ONES_LSB = 8;
   localparam int MIN_TENS_LSB = 12;

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit: counts 0..LIMIT on inc, rolls to 0 and raises carry at LIMIT.
// zero forces the digit to 0 and takes priority over inc.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] LIMIT = BCD_ONES_MAX
) (
   input  logic       clock_in,
   input  logic       clear,
   input  logic       inc,
   input  logic       zero,
   output logic [3:0] q,
   output logic       carry
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   // NOTE: q_d gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      q_d = q_q;
      if (zero) begin
         q_d = 4'd0;
      end else if (inc) begin
         q_d = (q_q == LIMIT) ? 4'd0 : q_q + 4'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples its pre-edge inputs.
   always_ff @(posedge clock_in) begin
      if (clear) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = inc & (q_q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd.sv
// Minutes:seconds BCD stopwatch counting rising edges of the divider output,
// with run/pause, lap freeze and zero control from single-cycle button pulses.
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = 59
) (
   input  logic        clock_in,
   input  logic        clear,
   input  logic        tick_in,
   input  logic        start_stop,
   input  logic        lap,
   output logic [15:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        wrap
);

   localparam logic [3:0] MIN_TENS_MAX    = 4'(MIN_MAX / 10);
   localparam logic [3:0] MIN_ONES_AT_MAX = 4'(MIN_MAX % 10);

   sw_state_e   state_q, state_d;
   logic        tick_d;
   logic        tick_rise;
   logic        count_en;
   logic        at_max;
   logic        wrap_now;
   logic        zero_req;
   logic        zero_all;
   logic        snap_load;
   logic        wrap_q, wrap_d;
   logic [15:0] snap_q, snap_d;
   logic [15:0] count_bcd;

   logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
   logic        sec_ones_carry, sec_tens_carry, min_ones_carry, min_tens_carry;

   // The divider output is sampled as data; only a 0->1 transition advances time.
   assign tick_rise = tick_in & ~tick_d;
   assign count_en  = tick_rise & ((state_q == RUN) | (state_q == LAP));

   assign at_max   = (min_tens == MIN_TENS_MAX) && (min_ones == MIN_ONES_AT_MAX) &&
                     (sec_tens == BCD_TENS_MAX) && (sec_ones == BCD_ONES_MAX);
   assign wrap_now = count_en & at_max;

   // A tens-of-minutes overflow can only coincide with the wrap; folding it in keeps any rollover at 00:00.
   assign zero_all = zero_req | wrap_now | min_tens_carry;

   bcd_digit_counter #(.LIMIT(BCD_ONES_MAX)) u_sec_ones (
      .clock_in (clock_in),
      .clear    (clear),
      .inc      (count_en),
      .zero     (zero_all),
      .q        (sec_ones),
      .carry    (sec_ones_carry)
   );

   bcd_digit_counter #(.LIMIT(BCD_TENS_MAX)) u_sec_tens (
      .clock_in (clock_in),
      .clear    (clear),
      .inc      (sec_ones_carry),
      .zero     (zero_all),
      .q        (sec_tens),
      .carry    (sec_tens_carry)
   );

   bcd_digit_counter #(.LIMIT(BCD_ONES_MAX)) u_min_ones (
      .clock_in (clock_in),
      .clear    (clear),
      .inc      (sec_tens_carry),
      .zero     (zero_all),
      .q        (min_ones),
      .carry    (min_ones_carry)
   );

   bcd_digit_counter #(.LIMIT(MIN_TENS_MAX)) u_min_tens (
      .clock_in (clock_in),
      .clear    (clear),
      .inc      (min_ones_carry),
      .zero     (zero_all),
      .q        (min_tens),
      .carry    (min_tens_carry)
   );

   always_comb begin
      count_bcd = 16'd0;
      count_bcd[MIN_TENS_LSB +: 4] = min_tens;
      count_bcd[MIN_ONES_LSB +: 4] = min_ones;
      count_bcd[SEC_TENS_LSB +: 4] = sec_tens;
      count_bcd[SEC_ONES_LSB +: 4] = sec_ones;
   end

   // start_stop always outranks lap when both arrive in the same cycle.
   always_comb begin
      state_d   = state_q;
      snap_load = 1'b0;
      zero_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_stop) state_d = RUN;
         end
         RUN: begin
            if (start_stop) begin
               state_d = PAUSE;
            end else if (lap) begin
               state_d   = LAP;
               snap_load = 1'b1;
            end
         end
         LAP: begin
            if (start_stop) begin
               state_d = PAUSE;
            end else if (lap) begin
               state_d = RUN;
            end
         end
         PAUSE: begin
            if (start_stop) begin
               state_d = RUN;
            end else if (lap) begin
               state_d  = IDLE;
               zero_req = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The snapshot captures the count as it stood before any coincident tick.
   assign snap_d = snap_load ? count_bcd : snap_q;
   assign wrap_d = wrap_now;

   always_ff @(posedge clock_in) begin
      if (clear) begin
         state_q <= IDLE;
         tick_d  <= 1'b0;
         snap_q  <= 16'd0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_d  <= tick_in;
         snap_q  <= snap_d;
         wrap_q  <= wrap_d;
      end
   end

   assign disp_bcd   = (state_q == LAP) ? snap_q : count_bcd;
   assign running    = (state_q == RUN) | (state_q == LAP);
   assign lap_active = (state_q == LAP);
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: an elapsed-seconds reference model checked every cycle,
// plus directed scenarios with hand-computed expected displays.
module tb_stopwatch_bcd;

   localparam int MIN_MAX   = 59;
   localparam int LAST_SECS = (MIN_MAX + 1) * 60 - 1;

   logic        clk;
   logic        clear;
   logic        tick_in;
   logic        start_stop;
   logic        lap;
   logic [15:0] disp_bcd;
   logic        running;
   logic        lap_active;
   logic        wrap;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   bit tk = 1'b0;

   stopwatch_bcd #(.MIN_MAX(MIN_MAX)) dut (
      .clock_in   (clk),
      .clear      (clear),
      .tick_in    (tick_in),
      .start_stop (start_stop),
      .lap        (lap),
      .disp_bcd   (disp_bcd),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_e;
   typedef struct {
      mode_e mode;
      int    secs;
      int    snap;
      bit    prev_tick;
      bit    wrap;
   } model_t;

   model_t m;

   function automatic logic [15:0] to_bcd(input int secs);
      int mins, s;
      mins = secs / 60;
      s    = secs % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic model_t model_step(input model_t c, input bit clr, input bit ss,
                                         input bit lp, input bit tck);
      model_t n;
      n = c;
      n.wrap = 1'b0;
      if (clr) begin
         n.mode = M_IDLE;
         n.secs = 0;
         n.snap = 0;
         n.prev_tick = 1'b0;
         return n;
      end
      n.prev_tick = tck;
      if ((c.mode == M_RUN || c.mode == M_LAP) && tck && !c.prev_tick) begin
         if (c.secs == LAST_SECS) begin
            n.secs = 0;
            n.wrap = 1'b1;
         end else begin
            n.secs = c.secs + 1;
         end
      end
      if (ss) begin
         case (c.mode)
            M_IDLE:  n.mode = M_RUN;
            M_RUN:   n.mode = M_PAUSE;
            M_LAP:   n.mode = M_PAUSE;
            M_PAUSE: n.mode = M_RUN;
         endcase
      end else if (lp) begin
         case (c.mode)
            M_IDLE:  n.mode = M_IDLE;
            M_RUN: begin
               n.mode = M_LAP;
               n.snap = c.secs;
            end
            M_LAP:   n.mode = M_RUN;
            M_PAUSE: begin
               n.mode = M_IDLE;
               n.secs = 0;
            end
         endcase
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_step(m, clear, start_stop, lap, tick_in);

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model disp_bcd", disp_bcd,
               (m.mode == M_LAP) ? to_bcd(m.snap) : to_bcd(m.secs));
         check("model running", 16'(running), 16'(m.mode == M_RUN || m.mode == M_LAP));
         check("model lap_active", 16'(lap_active), 16'(m.mode == M_LAP));
         check("model wrap", 16'(wrap), 16'(m.wrap));
      end
   end

   // Apply inputs for one rising edge and return at the following falling edge.
   task automatic step(input bit clr, input bit ss, input bit lp, input bit tck);
      clear      = clr;
      start_stop = ss;
      lap        = lp;
      tk         = tck;
      tick_in    = tck;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic restart();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      clear      = 1'b1;
      start_stop = 1'b0;
      lap        = 1'b0;
      tick_in    = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("reset disp_bcd", disp_bcd, 16'h0000);
      check("reset running", 16'(running), 16'h0000);
      check("reset lap_active", 16'(lap_active), 16'h0000);
      check("reset wrap", 16'(wrap), 16'h0000);

      // Clear during a live count.
      restart();
      ticks(37);
      check("count 00:37", disp_bcd, 16'h0037);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("clear mid-run disp", disp_bcd, 16'h0000);
      check("clear mid-run running", 16'(running), 16'h0000);

      // Seconds-to-minutes carry.
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(70);
      check("carry 01:10", disp_bcd, 16'h0110);
      check("carry running", 16'(running), 16'h0001);

      // Full-range wrap.
      restart();
      ticks(LAST_SECS);
      check("preload 59:59", disp_bcd, 16'h5959);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("wrap disp", disp_bcd, 16'h0000);
      check("wrap pulse", 16'(wrap), 16'h0001);
      check("wrap still running", 16'(running), 16'h0001);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("wrap one cycle", 16'(wrap), 16'h0000);

      // Lap freeze and release.
      restart();
      ticks(5);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(3);
      check("lap frozen", disp_bcd, 16'h0005);
      check("lap active", 16'(lap_active), 16'h0001);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("lap release", disp_bcd, 16'h0008);

      // Pause holds, lap in pause zeroes, idle ignores ticks.
      restart();
      ticks(12);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(4);
      check("pause hold", disp_bcd, 16'h0012);
      check("pause running", 16'(running), 16'h0000);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("pause zero", disp_bcd, 16'h0000);
      ticks(3);
      check("idle ignores ticks", disp_bcd, 16'h0000);

      // start_stop and lap together in RUN: pause wins, no snapshot.
      restart();
      ticks(3);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("ss+lap lap_active", 16'(lap_active), 16'h0000);
      check("ss+lap running", 16'(running), 16'h0000);
      check("ss+lap disp", disp_bcd, 16'h0003);

      // Tick coinciding with pause is counted; with resume it is not.
      restart();
      ticks(20);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("pause+tick disp", disp_bcd, 16'h0021);
      check("pause+tick running", 16'(running), 16'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check("resume+tick disp", disp_bcd, 16'h0021);
      check("resume+tick running", 16'(running), 16'h0001);

      // Lap coinciding with a tick snapshots the pre-increment value.
      restart();
      ticks(5);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("lap+tick snapshot", disp_bcd, 16'h0005);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("lap+tick live", disp_bcd, 16'h0006);

      // Randomized control and tick traffic against the model.
      for (int i = 0; i < 20000; i++) begin
         bit r_clr, r_ss, r_lp, r_tk;
         r_clr = ($urandom_range(0, 599) == 0);
         r_ss  = ($urandom_range(0, 29) == 0);
         r_lp  = ($urandom_range(0, 24) == 0);
         r_tk  = ($urandom_range(0, 2) == 0) ? ~tk : tk;
         step(r_clr, r_ss, r_lp, r_tk);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
